// File: rtl/spart_if.sv
// Driver-side bus and serial lines of the SPART responder, except the tristate
// databus, which stays a plain inout port on the responder.
interface spart_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;
  logic       txd;
  logic       rxd;

  modport master (output iocs, iorw, ioaddr, rxd, input rda, tbr, txd);
  modport slave  (input iocs, iorw, ioaddr, rxd, output rda, tbr, txd);
endinterface

// File: rtl/spart_responder.sv
// SPART responder: four-register bus decode, 16x baud generator,
// and 8N1 transmit/receive engines.
module spart_responder #(
  parameter logic [15:0] DIV_RESET = 16'h0516
) (
  input  logic      clk,
  input  logic      rst,
  spart_if.slave    bus,
  inout  wire [7:0] databus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [15:0] div_q, div_d, baud_q, baud_d, reload;
  logic [7:0]  tx_buf_q, tx_buf_d, tx_sh_q, tx_sh_d;
  logic [7:0]  rx_buf_q, rx_buf_d, rx_sh_q, rx_sh_d, rd_data;
  logic [3:0]  tx_tcnt_q, tx_tcnt_d, rx_tcnt_q, rx_tcnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [1:0]  tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic        tbr_q, tbr_d, rda_q, rda_d, ovr_q, ovr_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_stop_ok;
  logic        wr_en, rd_en, rd_clr, div_wr, baud_tick, tx_bit_end, rx_bit_end;
  logic [7:0]  wr_data;

  assign wr_data   = databus;
  assign wr_en     = bus.iocs & ~bus.iorw;
  assign rd_en     = bus.iocs & bus.iorw;
  assign rd_clr    = rd_en & (bus.ioaddr == 2'b00);
  assign div_wr    = wr_en & bus.ioaddr[1];
  assign baud_tick = (baud_q == 16'd0);

  always_comb begin
    case (bus.ioaddr)
      2'b00:   rd_data = rx_buf_q;
      2'b01:   rd_data = {5'b0, ovr_q, tbr_q, rda_q};
      2'b10:   rd_data = div_q[7:0];
      default: rd_data = div_q[15:8];
    endcase
  end

  assign databus = rd_en ? rd_data : 8'hzz;

  // A divisor write reloads from the new value so the next tick follows it.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    div_d = div_q;
    if (wr_en && bus.ioaddr == 2'b10) div_d[7:0]  = wr_data;
    if (wr_en && bus.ioaddr == 2'b11) div_d[15:8] = wr_data;
    reload = (div_d == 16'd0) ? 16'd0 : div_d - 16'd1;
    baud_d = (div_wr || baud_tick) ? reload : baud_q - 16'd1;
  end

  assign tx_bit_end = baud_tick && (tx_tcnt_q == 4'hf);
  assign rx_bit_end = baud_tick && (rx_tcnt_q == 4'hf);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_buf_d   = tx_buf_q;
    tbr_d      = tbr_q;
    if (wr_en && bus.ioaddr == 2'b00 && tbr_q) begin
      tx_buf_d = wr_data;
      tbr_d    = 1'b0;
    end
    if (baud_tick) tx_tcnt_d = tx_tcnt_q + 4'd1;
    case (tx_state_q)
      ST_IDLE: if (!tbr_q) begin
        tx_sh_d    = tx_buf_q;
        tbr_d      = 1'b1;
        tx_tcnt_d  = 4'd0;
        tx_state_d = ST_START;
      end
      ST_START: if (tx_bit_end) begin
        tx_bit_d   = 3'd0;
        tx_state_d = ST_DATA;
      end
      ST_DATA: if (tx_bit_end) begin
        tx_sh_d  = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
      end
      default: if (tx_bit_end) begin
        // A byte waiting in tx_buf chains straight into the next start bit.
        if (!tbr_q) begin
          tx_sh_d    = tx_buf_q;
          tbr_d      = 1'b1;
          tx_state_d = ST_START;
        end else begin
          tx_state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    case (tx_state_q)
      ST_START: bus.txd = 1'b0;
      ST_DATA:  bus.txd = tx_sh_q[0];
      default:  bus.txd = 1'b1;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_buf_d   = rx_buf_q;
    rda_d      = rda_q;
    ovr_d      = ovr_q;
    rx_stop_ok = 1'b0;
    if (baud_tick) rx_tcnt_d = rx_tcnt_q + 4'd1;
    case (rx_state_q)
      ST_IDLE: if (rx_prev_q && !rx_s2_q) begin
        rx_tcnt_d  = 4'd0;
        rx_state_d = ST_START;
      end
      ST_START: if (baud_tick && rx_tcnt_q == 4'd7) begin
        rx_tcnt_d  = 4'd0;
        rx_bit_d   = 3'd0;
        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_bit_end) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
      end
      default: if (rx_bit_end) begin
        rx_stop_ok = rx_s2_q;
        rx_state_d = ST_IDLE;
      end
    endcase
    // A byte landing on the same edge as a buffer read wins over the clear.
    if (rx_stop_ok) begin
      rx_buf_d = rx_sh_q;
      rda_d    = 1'b1;
      ovr_d    = rda_q & ~rd_clr;
    end else if (rd_clr) begin
      rda_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  assign bus.tbr = tbr_q;
  assign bus.rda = rda_q;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      div_q      <= DIV_RESET;
      baud_q     <= DIV_RESET - 16'd1;
      tx_state_q <= ST_IDLE;
      tx_tcnt_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_sh_q    <= 8'h00;
      tx_buf_q   <= 8'h00;
      tbr_q      <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_tcnt_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_sh_q    <= 8'h00;
      rx_buf_q   <= 8'h00;
      rda_q      <= 1'b0;
      ovr_q      <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      div_q      <= div_d;
      baud_q     <= baud_d;
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_buf_q   <= tx_buf_d;
      tbr_q      <= tbr_d;
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_buf_q   <= rx_buf_d;
      rda_q      <= rda_d;
      ovr_q      <= ovr_d;
      rx_s1_q    <= bus.rxd;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
    end
  end

endmodule

// File: tb/tb_spart_responder.sv
// Directed bench for spart_responder: register access, baud timing, TX/RX frames,
// receive error cases and reset in the middle of a transmit.
module tb_spart_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spart_if   bif ();
  wire [7:0] databus;
  logic      tb_en;
  logic [7:0] tb_d;
  assign databus = tb_en ? tb_d : 8'hzz;

  spart_responder dut (.clk(clk), .rst(rst), .bus(bif), .databus(databus));

  int vectors = 0;
  int miscompares = 0;

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bif.iocs = 1'b1; bif.iorw = 1'b0; bif.ioaddr = a; tb_en = 1'b1; tb_d = d;
    @(negedge clk);
    bif.iocs = 1'b0; tb_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bif.iocs = 1'b1; bif.iorw = 1'b1; bif.ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    bif.iocs = 1'b0; bif.iorw = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    bif.rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bif.rxd = d[i];
      repeat (16) @(negedge clk);
    end
    bif.rxd = stop;
    repeat (16) @(negedge clk);
    bif.rxd = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    rst = 1'b1; bif.iocs = 1'b0; bif.iorw = 1'b0; bif.ioaddr = 2'b00; bif.rxd = 1'b1;
    tb_en = 1'b0; tb_d = 8'h00;
    repeat (2) @(negedge clk);
    vectors++; if (bif.txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd: got %b want 1", bif.txd); end
    vectors++; if (bif.tbr !== 1'b1) begin miscompares++; $display("FAIL reset_tbr: got %b want 1", bif.tbr); end
    vectors++; if (bif.rda !== 1'b0) begin miscompares++; $display("FAIL reset_rda: got %b want 0", bif.rda); end
    rst = 1'b0;
    tb_en = 1'b1; tb_d = 8'h5A;
    #1;
    vectors++; if (databus !== 8'h5A) begin miscompares++; $display("FAIL bus_released: got %h want 5a", databus); end
    tb_en = 1'b0;
    bus_read(2'b01, r);
    vectors++; if (r !== 8'h02) begin miscompares++; $display("FAIL reset_status: got %h want 02", r); end
    bus_read(2'b10, r);
    vectors++; if (r !== 8'h16) begin miscompares++; $display("FAIL reset_div_lo: got %h want 16", r); end
    bus_read(2'b11, r);
    vectors++; if (r !== 8'h05) begin miscompares++; $display("FAIL reset_div_hi: got %h want 05", r); end
  endtask

  task automatic test_divisor();
    logic [7:0] r;
    int n;
    bus_write(2'b10, 8'h03);
    bus_write(2'b11, 8'h00);
    bus_read(2'b10, r);
    vectors++; if (r !== 8'h03) begin miscompares++; $display("FAIL div_lo_readback: got %h want 03", r); end
    bus_read(2'b11, r);
    vectors++; if (r !== 8'h00) begin miscompares++; $display("FAIL div_hi_readback: got %h want 00", r); end
    // Bit 0 of 8'h01 is the only high data bit: its width is 16 ticks of 3 cycles.
    bus_write(2'b00, 8'h01);
    n = 0;
    @(negedge clk);
    while (bif.txd === 1'b0 && n < 300) begin @(negedge clk); n++; end
    n = 0;
    while (bif.txd === 1'b1 && n < 300) begin @(negedge clk); n++; end
    vectors++; if (n != 48) begin miscompares++; $display("FAIL div3_bit_width: got %0d cycles want 48", n); end
    repeat (500) @(negedge clk);
    vectors++; if (bif.txd !== 1'b1 || bif.tbr !== 1'b1) begin miscompares++; $display("FAIL div3_frame_end: txd %b tbr %b want 1 1", bif.txd, bif.tbr); end
  endtask

  task automatic test_tx();
    logic [9:0] frame;
    int errs;
    frame = {1'b1, 8'hA5, 1'b0};
    bus_write(2'b10, 8'h01);
    bus_write(2'b00, 8'hA5);
    vectors++; if (bif.tbr !== 1'b0) begin miscompares++; $display("FAIL tx_tbr_drop: got %b want 0", bif.tbr); end
    bif.iocs = 1'b1; bif.iorw = 1'b0; bif.ioaddr = 2'b00; tb_en = 1'b1; tb_d = 8'hFF;
    @(negedge clk);
    bif.iocs = 1'b0; tb_en = 1'b0;
    vectors++; if (bif.tbr !== 1'b1) begin miscompares++; $display("FAIL tx_tbr_rise: got %b want 1", bif.tbr); end
    for (int k = 0; k < 10; k++) begin
      errs = 0;
      for (int j = 0; j < 16; j++) begin
        if (bif.txd !== frame[k]) errs++;
        @(negedge clk);
      end
      vectors++; if (errs != 0) begin miscompares++; $display("FAIL tx_bit%0d: %0d of 16 cycles off, want level %b", k, errs, frame[k]); end
    end
    errs = 0;
    for (int j = 0; j < 32; j++) begin
      if (bif.txd !== 1'b1) errs++;
      @(negedge clk);
    end
    vectors++; if (errs != 0) begin miscompares++; $display("FAIL tx_ignored_write: %0d low cycles after frame, want 0", errs); end
  endtask

  task automatic test_back_to_back();
    bus_write(2'b00, 8'h0F);
    bus_write(2'b00, 8'hF0);
    vectors++; if (bif.tbr !== 1'b0) begin miscompares++; $display("FAIL b2b_held: tbr %b want 0", bif.tbr); end
    repeat (158) @(negedge clk);
    vectors++; if (bif.txd !== 1'b1) begin miscompares++; $display("FAIL b2b_stop1: txd %b want 1", bif.txd); end
    @(negedge clk);
    vectors++; if (bif.txd !== 1'b0 || bif.tbr !== 1'b1) begin miscompares++; $display("FAIL b2b_start2: txd %b tbr %b want 0 1", bif.txd, bif.tbr); end
    repeat (72) @(negedge clk);
    vectors++; if (bif.txd !== 1'b0) begin miscompares++; $display("FAIL b2b_bit3: txd %b want 0", bif.txd); end
    repeat (16) @(negedge clk);
    vectors++; if (bif.txd !== 1'b1) begin miscompares++; $display("FAIL b2b_bit4: txd %b want 1", bif.txd); end
    repeat (100) @(negedge clk);
  endtask

  task automatic test_rx();
    logic [7:0] r;
    send_frame(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    vectors++; if (bif.rda !== 1'b1) begin miscompares++; $display("FAIL rx_rda: got %b want 1", bif.rda); end
    bus_read(2'b01, r);
    vectors++; if (r !== 8'h03) begin miscompares++; $display("FAIL rx_status: got %h want 03", r); end
    bus_read(2'b00, r);
    vectors++; if (r !== 8'h3C) begin miscompares++; $display("FAIL rx_data: got %h want 3c", r); end
    vectors++; if (bif.rda !== 1'b0) begin miscompares++; $display("FAIL rx_rda_clear: got %b want 0", bif.rda); end
  endtask

  task automatic test_rx_errors();
    logic [7:0] r;
    @(negedge clk);
    bif.rxd = 1'b0;
    repeat (8) @(negedge clk);
    bif.rxd = 1'b1;
    repeat (200) @(negedge clk);
    vectors++; if (bif.rda !== 1'b0) begin miscompares++; $display("FAIL rx_glitch: rda %b want 0", bif.rda); end
    send_frame(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    vectors++; if (bif.rda !== 1'b0) begin miscompares++; $display("FAIL rx_framing: rda %b want 0", bif.rda); end
    bus_read(2'b00, r);
    vectors++; if (r !== 8'h3C) begin miscompares++; $display("FAIL rx_framing_buf: got %h want 3c", r); end
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(2'b01, r);
    vectors++; if (r !== 8'h07) begin miscompares++; $display("FAIL rx_overrun_status: got %h want 07", r); end
    bus_read(2'b00, r);
    vectors++; if (r !== 8'h22) begin miscompares++; $display("FAIL rx_overrun_data: got %h want 22", r); end
    bus_read(2'b01, r);
    vectors++; if (r !== 8'h02) begin miscompares++; $display("FAIL rx_overrun_clear: got %h want 02", r); end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] r;
    int lows;
    bus_write(2'b00, 8'h00);
    repeat (88) @(negedge clk);
    vectors++; if (bif.txd !== 1'b0) begin miscompares++; $display("FAIL midtx_bit4: txd %b want 0", bif.txd); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (bif.txd !== 1'b1 || bif.tbr !== 1'b1) begin miscompares++; $display("FAIL midtx_reset: txd %b tbr %b want 1 1", bif.txd, bif.tbr); end
    rst = 1'b0;
    lows = 0;
    for (int j = 0; j < 300; j++) begin
      if (bif.txd !== 1'b1) lows++;
      @(negedge clk);
    end
    vectors++; if (lows != 0 || bif.tbr !== 1'b1) begin miscompares++; $display("FAIL midtx_residual: %0d low cycles tbr %b want 0 1", lows, bif.tbr); end
    bus_read(2'b10, r);
    vectors++; if (r !== 8'h16) begin miscompares++; $display("FAIL midtx_div_reset: got %h want 16", r); end
  endtask

  initial begin
    test_reset();
    test_divisor();
    test_tx();
    test_back_to_back();
    test_rx();
    test_rx_errors();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/spart_responder.md
# spart_responder

Bus-side responder and serial engine for the SPART (special-purpose asynchronous receiver/transmitter) at the far end of the processor driver's iocs/iorw/ioaddr/databus interface. It decodes bus cycles into four registers (TX/RX buffer, status, divisor low, divisor high) and generates 16x-oversampled baud ticks from the programmed divisor. It transmits 8N1 frames on txd and receives 8N1 frames from rxd, reporting tbr and rda back to the driver.

## Interface
- DIV_RESET, 16'h0516, divisor value loaded at reset (2400 baud at 50 MHz, 16x oversample)
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- iocs  input  1  chip select, active-high; no register access when 0
- iorw  input  1  1 = read, 0 = write
- ioaddr  input  2  00 TX/RX buffer, 01 status, 10 divisor low, 11 divisor high
- databus  inout  8  bidirectional data; driven only while iocs=1 and iorw=1, else 8'hzz
- rda  output  1  receive data available
- tbr  output  1  transmit buffer ready (empty)
- txd  output  1  serial transmit line, idle high
- rxd  input  1  serial receive line, asynchronous

## Operation
- Writes: on a rising edge with iocs=1 and iorw=0, databus is sampled.
  - 00: if tbr=1, load tx_buf and clear tbr; if tbr=0, ignore the write.
  - 10/11: load div[7:0] / div[15:8]. Writing the divisor restarts the baud counter.
  - 01: ignored.
- Reads (combinational drive while iocs=1 and iorw=1):
  - 00: rx_buf. On the edge ending the read cycle, clear rda and ovr.
  - 01: {5'b0, ovr, tbr, rda}.
  - 10/11: div low/high.
- Baud generator: 16-bit down counter, reloads to div-1 and emits a one-cycle tick on reaching 0. Tick period is div cycles; div=0 or div=1 gives a tick every cycle.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE: txd=1. If tx_buf is full, move it to the shifter, set tbr=1, reset the tick count and go to START.
  - Each bit lasts 16 ticks. START drives 0. DATA drives bits 0..7, LSB first. STOP drives 1.
  - After STOP, return to IDLE. A byte already in tx_buf starts immediately, so frames go back-to-back with no gap.
- RX FSM (IDLE, START, DATA, STOP):
  - rxd passes through a 2-flop synchronizer. A falling edge in IDLE enters START.
  - At tick 8 of START, if rxd_s=1 (glitch), return to IDLE. Otherwise sample each data bit every 16 ticks (mid-bit), LSB first.
  - At the STOP mid-sample:
    - rxd_s=1: load rx_buf and set rda. If rda was already 1, overwrite rx_buf and set ovr.
    - rxd_s=0 (framing error): discard the byte; rda is unchanged.
  - Return to IDLE after the stop sample.
- Simultaneous events: if a new byte completes on the same edge as a buffer read, the new byte wins (rda stays 1, ovr=0).
- Reset mid-frame aborts both FSMs immediately. Reset values:
  - txd=1, tbr=1, rda=0, ovr=0
  - tx_buf=0, rx_buf=0, div=DIV_RESET, baud counter=DIV_RESET-1
  - databus released (z)

## Timing
- Write-to-tbr: tbr=0 the cycle after the write edge. tbr returns to 1 on the cycle the TX FSM leaves IDLE, typically 1 cycle later.
- Write-to-txd-low: at most 2 cycles after the write edge when the transmitter is idle.
- Frame length: 160 ticks = 160*div cycles. The stop bit holds for 16 ticks.
- RX latency: rda rises within 2 cycles (synchronizer) of the mid-stop-bit tick.
- Read data is valid in the same cycle that iocs/iorw/ioaddr are valid. There are no wait states.

## Test plan
- Reset: assert rst for 2 cycles. Check txd=1, tbr=1, rda=0, databus=z, and status read = 8'h02.
- Divisor program: write 8'h03 to addr 10 and 8'h00 to addr 11. Read back 03/00 and check a baud tick every 3 cycles.
- TX: with div=1, write 8'hA5 to addr 00.
  - tbr drops, then rises.
  - txd shows start 0, then 1,0,1,0,0,1,0,1, then stop 1, each bit 16 cycles.
  - A write issued while tbr=0 is ignored.
- RX: with div=1, drive frame 8'h3C on rxd at 16 cycles/bit. Check rda=1, addr 00 read = 8'h3C, and rda=0 after the read.
- RX errors:
  - An 8-cycle low glitch on rxd produces no rda.
  - A frame with stop bit 0 produces no rda.
  - Two frames with no read in between give ovr=1 and rx_buf = second byte.
- Reset mid-TX: assert rst during DATA bit 4. Check txd=1, tbr=1 next cycle, and no residual frame afterwards.
